inv_round: RTL
==============

INV_ROUND -- requirements
Module: inv_round

Interface
REQ-001 Parameter WORD, default 64: SPECK word width in bits; block width is 2*WORD.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 signal_start  input  1  request to run one inverse round; sampled only in IDLE.
REQ-005 subkey  input  WORD  round key, same key the forward round used.
REQ-006 ciphertext  input  2*WORD  input block; x = bits [2*WORD-1:WORD], y = bits [WORD-1:0].
REQ-007 plaintext  output  2*WORD  registered result block, same x/y packing.
REQ-008 finished  output  1  high for exactly one cycle when plaintext is valid.
REQ-009 state_response  output  4  current FSM state encoding.

Function
REQ-010 The block SHALL compute one SPECK inverse round: y' = ROR(x XOR y, BETA); x' = ROL((x XOR k) - y', ALPHA), where ALPHA=8 and BETA=3.
REQ-011 Subtraction SHALL be modulo 2^WORD; borrow is discarded.
REQ-012 Rotations SHALL be over WORD bits, with no sign or width extension.
REQ-013 FSM states and encodings: IDLE=0, LOAD=1, UNDO_Y=2, UNDO_X=3, DONE=4; other codes SHALL go to IDLE on the next edge.
REQ-014 IDLE -> LOAD when signal_start=1; otherwise stay in IDLE.
REQ-015 LOAD: capture ciphertext and subkey into internal registers; next state UNDO_Y.
REQ-016 UNDO_Y: compute and store y'; next state UNDO_X.
REQ-017 UNDO_X: compute x', load plaintext register with {x', y'}; next state DONE.
REQ-018 DONE: finished=1; next state IDLE unconditionally.
REQ-019 Latency: start sampled at edge N gives finished=1 and a valid plaintext during the cycle after edge N+4.
REQ-020 signal_start SHALL be ignored in LOAD, UNDO_Y, UNDO_X and DONE.
REQ-021 Changes to ciphertext or subkey after LOAD SHALL NOT affect the current result.
REQ-022 plaintext SHALL hold its last value until the next UNDO_X.
REQ-023 With signal_start held high, the block SHALL restart on each IDLE visit, giving one result every 5 cycles.
REQ-024 finished SHALL be a registered decode of state == DONE, with no combinational path from inputs.

Reset
REQ-025 rst=1 SHALL, asynchronously, force state IDLE, plaintext=0, finished=0, state_response=0, and clear the internal x/y/k registers.
REQ-026 Reset asserted mid-operation SHALL drop the in-flight block; no finished pulse for it.
REQ-027 After rst deasserts, the first signal_start SHALL be honoured at the first rising edge.

Structure
REQ-028 Shared package speck_pkg SHALL hold: WORD default, ALPHA=8, BETA=3, and the 4-bit state encodings.
REQ-029 The forward round SHALL also use speck_pkg for its encodings.
REQ-030 No sub-module: rotations are wiring and the datapath is one subtractor plus XORs inside inv_round.

Verification
REQ-031 Zero vector: ciphertext=0, subkey=0, pulse start -> plaintext=0, finished one cycle, 5 cycles after start.
REQ-032 Key only: ciphertext=0, subkey=64'h1 -> plaintext=128'h0000000000000100_0000000000000000.
REQ-033 Borrow wrap: ciphertext=128'h0000000000000000_0000000000000008, subkey=0 -> plaintext=128'hFFFFFFFFFFFFFFFF_0000000000000001.
REQ-034 Round trip: the forward round on 128'h753778214125442A472D4B6150645367 with key 64'h244226452948404D, its ciphertext fed into inv_round -> plaintext equals the original block.
REQ-035 Reset mid-run: assert rst in UNDO_Y -> state_response=0 and plaintext=0 immediately; no finished pulse.
REQ-036 Busy ignore and hold: a start pulse during UNDO_X is ignored, and changing ciphertext after LOAD leaves the result unchanged; start held high -> finished every 5th cycle.

Source files
------------

// File: rtl/speck_pkg.sv
// speck_pkg: shared SPECK constants and round FSM state encodings
package speck_pkg;
    localparam int WORD_DEFAULT = 64;
    localparam int ALPHA = 8;
    localparam int BETA = 3;
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD   = 4'd1,
        UNDO_Y = 4'd2,
        UNDO_X = 4'd3,
        DONE   = 4'd4
    } state_t;
endpackage

// File: rtl/inv_round.sv
// inv_round: one SPECK inverse round as a five-state FSM with registered outputs
module inv_round
    import speck_pkg::*;
#(
    parameter int WORD = WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              signal_start,
    input  logic [WORD-1:0]   subkey,
    input  logic [2*WORD-1:0] ciphertext,
    output logic [2*WORD-1:0] plaintext,
    output logic              finished,
    output logic [3:0]        state_response
);
    state_t state;
    logic [WORD-1:0] x, y, k, xy, y_new, d, x_new;
    assign xy = x ^ y;
    assign y_new = (xy >> BETA) | (xy << (WORD - BETA));
    // y already holds y' by the time UNDO_X uses it
    assign d = (x ^ k) - y;
    assign x_new = (d << ALPHA) | (d >> (WORD - ALPHA));
    assign state_response = state;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            x <= '0;
            y <= '0;
            k <= '0;
            plaintext <= '0;
            finished <= 1'b0;
        end else begin
            finished <= state == DONE;
            case (state)
                IDLE: state <= signal_start ? LOAD : IDLE;
                LOAD: begin
                    x <= ciphertext[2*WORD-1:WORD];
                    y <= ciphertext[WORD-1:0];
                    k <= subkey;
                    state <= UNDO_Y;
                end
                UNDO_Y: begin
                    y <= y_new;
                    state <= UNDO_X;
                end
                UNDO_X: begin
                    plaintext <= {x_new, y};
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
